max_action_sequencer: RTL and testbench
=======================================

MAX_ACTION_SEQUENCER -- requirements
Module: max_action_sequencer

Interface
REQ-001 Parameter NUM_ACT, default 4: number of actions scanned per state; legal range 2..16.
REQ-002 Parameter ACT_W, default 2: action index width; the block SHALL be instantiated only with 2^ACT_W >= NUM_ACT.
REQ-003 Parameter ST_W, default 8: state index width.
REQ-004 clk  input  1  single clock; all logic is updated on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  scan request; sampled only in IDLE.
REQ-007 state_idx  input  ST_W  state whose Q-values are scanned; latched when start is accepted.
REQ-008 q_rd_en  output  1  Q-table read strobe.
REQ-009 q_rd_addr  output  ST_W+ACT_W  read address = {latched state, action index}.
REQ-010 q_rd_data  input  16  Q-value in sign-magnitude (bit15 = sign, bits14:0 = magnitude); valid exactly one cycle after q_rd_en.
REQ-011 busy  output  1  high while a scan is in progress.
REQ-012 done  output  1  one-cycle pulse: result valid.
REQ-013 max_q  output  16  maximum Q-value of the last completed scan.
REQ-014 max_act  output  ACT_W  action index of max_q.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-016 IDLE->ISSUE SHALL occur on the edge where start=1; state_idx is latched on that edge and the action counter is cleared to 0.
REQ-017 In ISSUE, q_rd_en SHALL be 1 and q_rd_addr SHALL be {latched state, counter}; the counter SHALL increment each cycle.
REQ-018 ISSUE->DRAIN SHALL occur after the cycle that issues action NUM_ACT-1; q_rd_en SHALL be 0 in DRAIN, DONE and IDLE.
REQ-019 DRAIN SHALL last one cycle while the final read data is compared; DRAIN->DONE follows.
REQ-020 DONE SHALL last one cycle with done=1; DONE->IDLE follows.
REQ-021 Timing: with start accepted at edge T, reads SHALL issue in cycles T+1..T+NUM_ACT, and done SHALL be high in cycle T+NUM_ACT+2.
REQ-022 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
REQ-023 Running-max update:
- Data returned for action 0 SHALL load the running max and index unconditionally.
- Each later datum SHALL replace them only if it is strictly greater.
REQ-024 Sign-magnitude ordering rules:
- positive > negative;
- both positive: larger magnitude wins;
- both negative: smaller magnitude wins;
- +0 and -0 compare equal.
REQ-025 Ties SHALL keep the lower action index.
REQ-026 max_q and max_act SHALL update on the edge entering DONE and SHALL hold until the next DONE; they SHALL NOT change during a scan.
REQ-027 start SHALL be ignored in ISSUE, DRAIN and DONE; no queuing.
REQ-028 Changes to state_idx after acceptance SHALL NOT affect the scan in progress.
REQ-029 A start in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back period of NUM_ACT+3 cycles.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the counter.
REQ-031 Reset values SHALL be: q_rd_en=0, q_rd_addr=0, busy=0, done=0, max_q=16'h0000, max_act=0.
REQ-032 A reset mid-scan SHALL abort the scan with no done pulse; the next start after release SHALL perform a full fresh scan.
REQ-033 start SHALL be ignored while rst_n=0.

Verification (NUM_ACT=4)
REQ-034 Scenario 1:
- state_idx=8'h05, Q={0x0003,0x0010,0x0007,0x0010};
- required: rd addrs 0x14,0x15,0x16,0x17 on consecutive cycles;
- required: done at T+6, max_q=0x0010, max_act=1.
REQ-035 Scenario 2:
- Q={0x8005,0x8002,0x8009,0x8002};
- required: max_q=0x8002, max_act=1.
REQ-036 Scenario 3:
- Q={0x8000,0x0000,0x8001,0x8003};
- required: max_q=0x8000, max_act=0 (±0 tie).
- Q={0x8004,0x0000,0x7FFF,0x8001};
- required: max_q=0x7FFF, max_act=2.
REQ-037 Scenario 4:
- start held high continuously;
- required: scans complete every 7 cycles, start is ignored while busy, and state_idx is changed mid-scan with no effect on addresses.
REQ-038 Scenario 5:
- rst_n=0 in cycle T+3 of a scan;
- required: all outputs reach reset values the next cycle and no done pulse occurs;
- required: the following scan returns the correct result.
REQ-039 Scenario 6:
- first scan gives max_q=0x0010;
- required: max_q stays 0x0010 throughout a second scan and updates only at its done.

Source files
------------

// File: rtl/max_action_sequencer.sv
// Max-action sequencer: scans NUM_ACT Q-table entries of one state and
// reports the largest sign-magnitude Q-value and its action index.
module max_action_sequencer #(
  parameter int NUM_ACT = 4,
  parameter int ACT_W   = 2,
  parameter int ST_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ST_W-1:0]       state_idx,
  output logic                  q_rd_en,
  output logic [ST_W+ACT_W-1:0] q_rd_addr,
  input  logic [15:0]           q_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           max_q,
  output logic [ACT_W-1:0]      max_act
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ST_W-1:0]   st_q, st_d;          // state index latched at start
  logic [ACT_W-1:0]  cnt_q, cnt_d;        // action being issued
  logic              vld_q, vld_d;        // q_rd_data carries a datum this cycle
  logic [ACT_W-1:0]  vact_q, vact_d;      // action that datum belongs to
  logic [15:0]       run_q, run_d;        // running maximum value
  logic [ACT_W-1:0]  run_act_q, run_act_d;
  logic [15:0]       max_q_q, max_q_d;    // published result
  logic [ACT_W-1:0]  max_act_q, max_act_d;
  logic [15:0]       cand_val;
  logic [ACT_W-1:0]  cand_act;

  // Strict sign-magnitude greater-than; -0 is folded onto +0 so they tie.
  function automatic logic sm_gt(input logic [15:0] a, input logic [15:0] b);
    logic neg_a;
    logic neg_b;
    logic res;
    neg_a = a[15] & (a[14:0] != 15'd0);
    neg_b = b[15] & (b[14:0] != 15'd0);
    if (neg_a != neg_b) begin
      res = neg_b;
    end else if (!neg_a) begin
      res = (a[14:0] > b[14:0]);
    end else begin
      res = (a[14:0] < b[14:0]);
    end
    return res;
  endfunction

  // Running max after folding in the current datum; action 0 always loads.
  always_comb begin
    cand_val = run_q;
    cand_act = run_act_q;
    if ((vact_q == {ACT_W{1'b0}}) || sm_gt(q_rd_data, run_q)) begin
      cand_val = q_rd_data;
      cand_act = vact_q;
    end else begin
      cand_val = run_q;
      cand_act = run_act_q;
    end
  end

  // Next-state logic of the scan FSM and its datapath.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    vact_d    = vact_q;
    run_d     = run_q;
    run_act_d = run_act_q;
    max_q_d   = max_q_q;
    max_act_d = max_act_q;

    if (vld_q) begin
      run_d     = cand_val;
      run_act_d = cand_act;
    end else begin
      run_d     = run_q;
      run_act_d = run_act_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          st_d    = state_idx;
          cnt_d   = {ACT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        vld_d  = 1'b1;
        vact_d = cnt_q;
        cnt_d  = cnt_q + {{(ACT_W-1){1'b0}}, 1'b1};
        if (cnt_q == ACT_W'(NUM_ACT - 1)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Final datum arrives now; publish the folded result on entry to DONE.
        state_d   = S_DONE;
        max_q_d   = cand_val;
        max_act_d = cand_act;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      st_q      <= {ST_W{1'b0}};
      cnt_q     <= {ACT_W{1'b0}};
      vld_q     <= 1'b0;
      vact_q    <= {ACT_W{1'b0}};
      run_q     <= 16'h0000;
      run_act_q <= {ACT_W{1'b0}};
      max_q_q   <= 16'h0000;
      max_act_q <= {ACT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      vact_q    <= vact_d;
      run_q     <= run_d;
      run_act_q <= run_act_d;
      max_q_q   <= max_q_d;
      max_act_q <= max_act_d;
    end
  end

  assign q_rd_en   = (state_q == S_ISSUE);
  assign q_rd_addr = q_rd_en ? {st_q, cnt_q} : {(ST_W+ACT_W){1'b0}};
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign max_q     = max_q_q;
  assign max_act   = max_act_q;

endmodule

// File: tb/tb_max_action_sequencer.sv
// Self-checking bench for max_action_sequencer (NUM_ACT=4, ACT_W=2, ST_W=8).
module tb_max_action_sequencer;

  localparam int NA = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  state_idx;
  logic        q_rd_en;
  logic [9:0]  q_rd_addr;
  logic [15:0] q_rd_data;
  logic        busy;
  logic        done;
  logic [15:0] max_q;
  logic [1:0]  max_act;

  max_action_sequencer #(.NUM_ACT(4), .ACT_W(2), .ST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state_idx(state_idx),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .busy(busy), .done(done), .max_q(max_q), .max_act(max_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] qmem [0:1023];
  logic [9:0]  addr_log [$];

  // Reference model state: m_p = edges since acceptance (0 = idle).
  int          cyc = 0;
  int          m_p = 0;
  int          m_acc = 0;
  bit          m_valid = 1'b0;
  logic [7:0]  m_lat = 8'h00;
  logic [15:0] m_max = 16'h0000;
  logic [1:0]  m_act = 2'd0;
  logic [15:0] m_res_q = 16'h0000;
  logic [1:0]  m_res_a = 2'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Signed integer ordering key: -0 and +0 both map to 0.
  function automatic int sm_key(input logic [15:0] v);
    if (v[15]) return -int'(v[14:0]);
    else return int'(v[14:0]);
  endfunction

  function automatic logic [15:0] rnd_q();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h0000;
      1: v = 16'h8000;
      2: v = {1'b0, 15'($urandom_range(0, 3))};
      3: v = {1'b1, 15'($urandom_range(0, 3))};
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Behavioural model: advance on each rising edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_valid = 1'b1;
      if (!rst_n) begin
        m_p = 0; m_max = 16'h0000; m_act = 2'd0;
      end else if (m_p == 0) begin
        if (start) begin
          m_p = 1; m_lat = state_idx; m_acc = cyc;
          m_res_a = 2'd0;
          m_res_q = qmem[{state_idx, 2'd0}];
          for (int a = 1; a < NA; a++) begin
            logic [9:0] ad;
            ad = {state_idx, a[1:0]};
            if (sm_key(qmem[ad]) > sm_key(m_res_q)) begin
              m_res_q = qmem[ad]; m_res_a = a[1:0];
            end
          end
        end
      end else if (m_p <= NA) begin
        m_p++;
      end else if (m_p == NA + 1) begin
        m_p = NA + 2; m_max = m_res_q; m_act = m_res_a;
      end else begin
        m_p = 0;
      end
    end
  end

  // Q-table responder: data for a read cycle appears just after the next edge.
  initial begin
    logic       pend;
    logic [9:0] a;
    q_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      pend = q_rd_en;
      a = q_rd_addr;
      @(posedge clk);
      #1;
      q_rd_data = pend ? qmem[a] : 16'($urandom);
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        logic ex_en;
        ex_en = (m_p >= 1) && (m_p <= NA);
        chk("q_rd_en", q_rd_en, ex_en);
        chk("q_rd_addr", q_rd_addr, ex_en ? {m_lat, 2'(m_p - 1)} : 10'd0);
        chk("busy", busy, (m_p >= 1) && (m_p <= NA + 1));
        chk("done", done, m_p == NA + 2);
        chk("max_q", max_q, m_max);
        chk("max_act", max_act, m_act);
        if (q_rd_en === 1'b1) addr_log.push_back(q_rd_addr);
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_p != 0 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("idle_timeout", g, 0);
  endtask

  // One scan with literal expectations; optionally checks max_q holds meanwhile.
  task automatic do_scan(input logic [7:0] st, input logic [15:0] q0, input logic [15:0] q1,
                         input logic [15:0] q2, input logic [15:0] q3,
                         input logic [15:0] eq, input logic [1:0] ea,
                         input bit hold, input logic [15:0] hold_q);
    bit seen;
    wait_idle();
    qmem[{st, 2'd0}] = q0; qmem[{st, 2'd1}] = q1;
    qmem[{st, 2'd2}] = q2; qmem[{st, 2'd3}] = q3;
    addr_log.delete();
    state_idx = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    state_idx = 8'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (hold) chk("hold_max_q", max_q, hold_q);
      @(negedge clk);
      state_idx = 8'($urandom);
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      // Cycle T+k begins at edge T+k-1, so done in cycle T+6 is NA+1 edges on.
      chk("done_latency", cyc - m_acc, NA + 1);
      chk("scan_max_q", max_q, eq);
      chk("scan_max_act", max_act, ea);
      chk("addr_count", addr_log.size(), NA);
      for (int k = 0; k < addr_log.size() && k < NA; k++)
        chk("rd_addr_seq", addr_log[k], {st, 2'(k)});
    end
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 1024; i++) qmem[i] = rnd_q();
    rst_n = 1'b0; start = 1'b1; state_idx = 8'h00;
    repeat (3) @(negedge clk);
    // Reset values (start is high during reset and must be ignored).
    chk("rst_q_rd_en", q_rd_en, 0);
    chk("rst_q_rd_addr", q_rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max_q", max_q, 16'h0000);
    chk("rst_max_act", max_act, 0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1 then 6: result 0x0010 must hold through the next scan.
    do_scan(8'h05, 16'h0003, 16'h0010, 16'h0007, 16'h0010, 16'h0010, 2'd1, 1'b0, 16'h0000);
    chk("s1_addr0", addr_log.size() > 0 ? addr_log[0] : 10'h3FF, 10'h014);
    do_scan(8'hA0, 16'h0001, 16'h0020, 16'h8005, 16'h001F, 16'h0020, 2'd1, 1'b1, 16'h0010);
    // Scenarios 2 and 3.
    do_scan(8'h11, 16'h8005, 16'h8002, 16'h8009, 16'h8002, 16'h8002, 2'd1, 1'b0, 16'h0000);
    do_scan(8'h22, 16'h8000, 16'h0000, 16'h8001, 16'h8003, 16'h8000, 2'd0, 1'b0, 16'h0000);
    do_scan(8'h23, 16'h8004, 16'h0000, 16'h7FFF, 16'h8001, 16'h7FFF, 2'd2, 1'b0, 16'h0000);

    // Scenario 5: reset sampled at the edge ending cycle T+3.
    wait_idle();
    state_idx = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_q_rd_en", q_rd_en, 0);
    chk("abort_max_q", max_q, 16'h0000);
    rst_n = 1'b1;
    dn = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) dn++; end
    chk("abort_no_done", dn, 0);
    do_scan(8'h33, 16'h8007, 16'h0004, 16'h0004, 16'h0002, 16'h0004, 2'd1, 1'b0, 16'h0000);

    // Scenario 4: start held high, state_idx churning; done every NA+3 cycles.
    wait_idle();
    start = 1'b1;
    dn = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      state_idx = 8'($urandom);
    end
    start = 1'b0;
    chk("b2b_done_count", dn, 10);

    // Randomized traffic with occasional resets, checked every cycle.
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      state_idx = 8'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
